// File: rtl/i2c_slave_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rx_if
// Purpose  : I2C pin and AXI-Stream output bundle for the i2c_slave_rx target.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_slave_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  scl_i;
    logic                  sda_i;
    logic                  sda_oe;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  busy;
    logic                  overrun;

    modport slave (
        input  scl_i, sda_i, m_axis_tready,
        output sda_oe, m_axis_tdata, m_axis_tvalid, busy, overrun
    );

    modport master (
        output scl_i, sda_i, m_axis_tready,
        input  sda_oe, m_axis_tdata, m_axis_tvalid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rx
// Purpose  : Write-only I2C target; oversamples scl/sda, ACKs its own address
//            and streams each received byte out on AXI-Stream.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_rx #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic          clk,
    input  logic          arst_n,
    i2c_slave_rx_if.slave bus
);

    localparam int c_ADDR_BITS = ADDR_WIDTH + 1;
    localparam int c_SR_W      = (DATA_WIDTH > c_ADDR_BITS) ? DATA_WIDTH : c_ADDR_BITS;
    localparam int c_CNT_W     = $clog2(c_SR_W) + 1;
    localparam logic [c_CNT_W-1:0] c_ADDR_CNT = c_CNT_W'(c_ADDR_BITS);
    localparam logic [c_CNT_W-1:0] c_DATA_CNT = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    // Synchronizers idle high so reset never fakes a bus event
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= bus.sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    state_t                r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_bit_cnt, w_cnt_nxt;
    logic [c_SR_W-1:0]     r_shift, w_shift_nxt;
    logic                  r_sda_oe, w_sda_oe_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
    logic                  r_tvalid, w_tvalid_nxt;

    logic w_scl_rise, w_scl_fall, w_scl_high, w_start, w_stop, w_addr_hit;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_scl_high = r_scl_s2 & r_scl_d;
    // While we pull sda low ourselves, sda transitions are not bus conditions
    assign w_start    = w_scl_high & ~r_sda_s2 &  r_sda_d & ~r_sda_oe;
    assign w_stop     = w_scl_high &  r_sda_s2 & ~r_sda_d & ~r_sda_oe;
    assign w_addr_hit = (r_shift[c_ADDR_BITS-1:1] == SLAVE_ADDR) && !r_shift[0];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
            r_tdata   <= w_tdata_nxt;
            r_tvalid  <= w_tvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_overrun_nxt = 1'b0;
        w_tdata_nxt   = r_tdata;
        w_tvalid_nxt  = r_tvalid & ~bus.m_axis_tready;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_cnt_nxt    = '0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise && (r_bit_cnt < c_ADDR_CNT)) begin
                        w_shift_nxt = {r_shift[c_SR_W-2:0], r_sda_s2};
                        w_cnt_nxt   = r_bit_cnt + c_CNT_ONE;
                    end else if (w_scl_fall && (r_bit_cnt == c_ADDR_CNT)) begin
                        if (w_addr_hit) begin
                            w_state_nxt  = S_ADDR_ACK;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt  = S_DATA;
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_busy_nxt   = 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_scl_rise && (r_bit_cnt < c_DATA_CNT)) begin
                        w_shift_nxt = {r_shift[c_SR_W-2:0], r_sda_s2};
                        w_cnt_nxt   = r_bit_cnt + c_CNT_ONE;
                    end else if (w_scl_fall && (r_bit_cnt == c_DATA_CNT)) begin
                        // A load in the handshake cycle keeps tvalid high
                        if (!r_tvalid || bus.m_axis_tready) begin
                            w_tdata_nxt  = r_shift[DATA_WIDTH-1:0];
                            w_tvalid_nxt = 1'b1;
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = S_DATA_ACK;
                        end else begin
                            w_overrun_nxt = 1'b1;
                            w_state_nxt   = S_IGNORE;
                        end
                    end
                end
                S_DATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt  = S_DATA;
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe        = r_sda_oe;
    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.busy          = r_busy;
    assign bus.overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_rx
// Purpose  : Directed bench for i2c_slave_rx with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx;

    localparam int c_Q = 5;   // clocks per quarter scl period

    logic clk = 1'b0;
    logic arst_n;
    logic sda_m;
    logic ack;
    int   vectors     = 0;
    int   miscompares = 0;
    int   pops        = 0;
    int   overruns    = 0;
    int   oe_cycles   = 0;
    int   oe_snap;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_slave_rx_if #(.DATA_WIDTH(8)) bus();

    // Open-drain bus: either side can pull sda low
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_slave_rx #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8),
        .SLAVE_ADDR (7'h50)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (arst_n === 1'b1) begin
            if (bus.overrun === 1'b1) overruns++;
            if (bus.sda_oe === 1'b1) oe_cycles++;
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
                pops++;
                chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("tdata", 32'(bus.m_axis_tdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_q();
        repeat (c_Q) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_m = 1'b1; wait_q();
        bus.scl_i = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        bus.scl_i = 1'b0; wait_q();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wait_q();
        bus.scl_i = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_q();
        bus.scl_i = 1'b1; wait_q(); wait_q();
        bus.scl_i = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        bus.scl_i = 1'b1; wait_q();
        a = ~bus.sda_i;
        wait_q();
        bus.scl_i = 1'b0; wait_q();
    endtask

    initial begin
        arst_n = 1'b0;
        bus.scl_i = 1'b1;
        sda_m = 1'b1;
        bus.m_axis_tready = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_sda_oe",  32'(bus.sda_oe), 32'd0);
        chk("rst_tvalid",  32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_tdata",   32'(bus.m_axis_tdata), 32'd0);
        chk("rst_busy",    32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        arst_n = 1'b1;
        wait_q();

        // Reset asserted in the middle of an address byte
        start_cond();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        arst_n = 1'b0;
        #1;
        chk("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("midrst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("midrst_busy",   32'(bus.busy), 32'd0);
        wait_q();
        arst_n = 1'b1;
        stop_cond();
        wait_q();

        // Single byte 0xA5 held without tready
        start_cond();
        send_byte(8'hA0, ack); chk("t1_addr_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack); chk("t1_data_ack", 32'(ack), 32'd1);
        chk("t1_busy_mid", 32'(bus.busy), 32'd1);
        chk("t1_tvalid",   32'(bus.m_axis_tvalid), 32'd1);
        chk("t1_tdata",    32'(bus.m_axis_tdata), 32'hA5);
        stop_cond(); wait_q();
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk("t1_tvalid_kept", 32'(bus.m_axis_tvalid), 32'd1);
        bus.m_axis_tready = 1'b1;
        wait_q();
        chk("t1_pops", 32'(pops), 32'd1);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Address mismatch
        oe_snap = oe_cycles;
        start_cond();
        send_byte(8'hA2, ack); chk("t2_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h3C, ack); chk("t2_data_nack", 32'(ack), 32'd0);
        stop_cond(); wait_q();
        chk("t2_no_oe", 32'(oe_cycles), 32'(oe_snap));
        chk("t2_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("t2_pops", 32'(pops), 32'd1);

        // Read request is refused
        start_cond();
        send_byte(8'hA1, ack); chk("t3_read_nack", 32'(ack), 32'd0);
        stop_cond(); wait_q();
        chk("t3_busy", 32'(bus.busy), 32'd0);
        chk("t3_tvalid", 32'(bus.m_axis_tvalid), 32'd0);

        // Multi-byte with tready high
        start_cond();
        send_byte(8'hA0, ack); chk("t4_addr_ack", 32'(ack), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), ack); chk("t4_data_ack", 32'(ack), 32'd1);
        end
        stop_cond(); wait_q();
        chk("t4_pops", 32'(pops), 32'd4);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure: second byte overruns
        bus.m_axis_tready = 1'b0;
        start_cond();
        send_byte(8'hA0, ack); chk("t5_addr_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'h11);
        send_byte(8'h11, ack); chk("t5_ack_11", 32'(ack), 32'd1);
        send_byte(8'h22, ack); chk("t5_nack_22", 32'(ack), 32'd0);
        chk("t5_overrun_cnt", 32'(overruns), 32'd1);
        chk("t5_tdata_held", 32'(bus.m_axis_tdata), 32'h11);
        chk("t5_tvalid_held", 32'(bus.m_axis_tvalid), 32'd1);
        stop_cond(); wait_q();
        chk("t5_tdata_after_stop", 32'(bus.m_axis_tdata), 32'h11);
        bus.m_axis_tready = 1'b1;
        wait_q();
        chk("t5_pops", 32'(pops), 32'd5);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // Repeated START after a partial data byte
        start_cond();
        send_byte(8'hA0, ack); chk("t6_addr_ack1", 32'(ack), 32'd1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        start_cond();
        send_byte(8'hA0, ack); chk("t6_addr_ack2", 32'(ack), 32'd1);
        exp_q.push_back(8'h77);
        send_byte(8'h77, ack); chk("t6_data_ack", 32'(ack), 32'd1);
        stop_cond(); wait_q();
        chk("t6_pops", 32'(pops), 32'd6);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_overrun_cnt", 32'(overruns), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
